// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl
// Memory-stage controller for a pipelined CPU. It issues data-cache requests
// for the instruction held in the EX/MEM latch, stalls the front of the
// pipeline while a request is outstanding, drives the MEM/WB latch controls,
// and latches a sticky halt.
//
// Ports
//   CLK, RST          clock, asynchronous active-high reset
//   exmem_valid       EX/MEM latch holds a real instruction (0 = bubble)
//   MemRead_in        decoded load control
//   MemWrite_in       decoded store control
//   Halt_in           decoded halt control
//   aluOutport_in     effective address / ALU result
//   storeData_in      store data (rt)
//   dhit, dmemload    cache completion strobe and read data
//   dmemREN, dmemWEN  cache read / write request
//   dmemaddr          cache request address
//   dmemstore         cache store data
//   memwb_writeEN     MEM/WB latch enable
//   memwb_flush       load a nop into MEM/WB
//   memwb_dmemload    load data presented to MEM/WB
//   stall_mem         freeze IF/ID/EX and the EX/MEM latch
//   halt_o            sticky halt
//   mem_stall_cnt     saturating count of cycles spent waiting on the cache
module mem_stage_ctrl (
    input  logic        CLK,
    input  logic        RST,
    input  logic        exmem_valid,
    input  logic        MemRead_in,
    input  logic        MemWrite_in,
    input  logic        Halt_in,
    input  logic [31:0] aluOutport_in,
    input  logic [31:0] storeData_in,
    input  logic        dhit,
    input  logic [31:0] dmemload,
    output logic        dmemREN,
    output logic        dmemWEN,
    output logic [31:0] dmemaddr,
    output logic [31:0] dmemstore,
    output logic        memwb_writeEN,
    output logic        memwb_flush,
    output logic [31:0] memwb_dmemload,
    output logic        stall_mem,
    output logic        halt_o,
    output logic [15:0] mem_stall_cnt
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t      state;
    state_t      cur_state;
    state_t      next_state;
    logic [31:0] load_q;
    logic        valid_eff;
    logic        mem_op;
    logic        load_done;

    always_comb begin
        // While reset is held the block behaves as IDLE with a bubble in
        // EX/MEM, so any outstanding request is dropped without waiting for
        // the registers to settle.
        cur_state      = RST ? IDLE : state;
        valid_eff      = exmem_valid & ~RST;
        mem_op         = valid_eff & (MemRead_in | MemWrite_in);
        next_state     = cur_state;
        dmemREN        = 1'b0;
        dmemWEN        = 1'b0;
        dmemaddr       = 32'd0;
        dmemstore      = 32'd0;
        memwb_writeEN  = 1'b0;
        memwb_flush    = 1'b0;
        stall_mem      = 1'b0;

        case (cur_state)
            IDLE: begin
                if (!valid_eff) begin
                    memwb_flush   = 1'b1;
                    memwb_writeEN = 1'b1;
                end else if (Halt_in) begin
                    // Halt outranks a memory op: the instruction retires
                    // without ever touching the cache.
                    memwb_writeEN = 1'b1;
                    next_state    = HALTED;
                end else if (mem_op) begin
                    dmemREN   = MemRead_in & ~MemWrite_in;
                    dmemWEN   = MemWrite_in;
                    dmemaddr  = aluOutport_in;
                    dmemstore = storeData_in;
                    if (dhit) begin
                        memwb_writeEN = 1'b1;
                    end else begin
                        stall_mem  = 1'b1;
                        next_state = WAIT;
                    end
                end else begin
                    memwb_writeEN = 1'b1;
                end
            end
            WAIT: begin
                // EX/MEM is frozen by stall_mem, so its inputs still describe
                // the outstanding request.
                dmemREN   = MemRead_in & ~MemWrite_in;
                dmemWEN   = MemWrite_in;
                dmemaddr  = aluOutport_in;
                dmemstore = storeData_in;
                if (dhit) begin
                    memwb_writeEN = 1'b1;
                    next_state    = IDLE;
                end else begin
                    stall_mem = 1'b1;
                end
            end
            HALTED: begin
                stall_mem = 1'b1;
            end
            default: begin
                next_state = IDLE;
            end
        endcase

        // Only a read completion carries fresh data; a store (including the
        // read+write case, where the write wins) leaves the last load visible.
        load_done      = dmemREN & dhit;
        memwb_dmemload = load_done ? dmemload : load_q;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state         <= IDLE;
            load_q        <= 32'd0;
            mem_stall_cnt <= 16'd0;
            halt_o        <= 1'b0;
        end else begin
            state <= next_state;
            if (load_done) begin
                load_q <= dmemload;
            end
            if (state == WAIT && mem_stall_cnt != 16'hFFFF) begin
                mem_stall_cnt <= mem_stall_cnt + 16'd1;
            end
            if (next_state == HALTED) begin
                halt_o <= 1'b1;
            end
        end
    end

endmodule

// File: doc/mem_stage_ctrl.md
MEM_STAGE_CTRL -- requirements
Module: mem_stage_ctrl

Interface
REQ-001 CLK  in  1  system clock; all state updates on rising edge.
REQ-002 RST  in  1  reset; asynchronous, active-high.
REQ-003 exmem_valid  in  1  EX/MEM latch holds a real instruction; 0 = bubble.
REQ-004 MemRead_in, MemWrite_in, Halt_in  in  1 each  decoded controls from the EX/MEM latch.
REQ-005 aluOutport_in  in  32  effective address or ALU result.
REQ-006 storeData_in  in  32  rt value to store.
REQ-007 dhit  in  1  data cache completes the current request this cycle.
REQ-008 dmemload  in  32  cache read data; valid when dhit=1.
REQ-009 dmemREN, dmemWEN  out  1 each  cache read/write request.
REQ-010 dmemaddr, dmemstore  out  32 each  request address and store data.
REQ-011 memwb_writeEN  out  1  enable for the MEM/WB latch.
REQ-012 memwb_flush  out  1  load a nop into the MEM/WB latch.
REQ-013 memwb_dmemload  out  32  load data presented to the MEM/WB latch.
REQ-014 stall_mem  out  1  freeze IF/ID/EX stages and the EX/MEM latch.
REQ-015 halt_o  out  1  sticky halt, reported to the system.
REQ-016 mem_stall_cnt  out  16  count of memory wait cycles.

Function
REQ-017 FSM states: IDLE, WAIT, HALTED; encoding is free.
REQ-018 mem op = exmem_valid & (MemRead_in | MemWrite_in).
REQ-019 IDLE, mem op:
  - dmemREN = MemRead_in & ~MemWrite_in; dmemWEN = MemWrite_in.
  - Both requests are driven combinationally in the same cycle.
  - dmemaddr = aluOutport_in; dmemstore = storeData_in.
REQ-020 IDLE, mem op, dhit=1:
  - memwb_writeEN=1; stall_mem=0; memwb_dmemload=dmemload.
  - Zero added latency; state stays IDLE.
REQ-021 IDLE, mem op, dhit=0:
  - stall_mem=1; memwb_writeEN=0; next state WAIT.
REQ-022 WAIT:
  - Hold dmemREN/dmemWEN/dmemaddr/dmemstore from the held EX/MEM inputs.
  - stall_mem=1 until dhit.
  - On dhit: memwb_writeEN=1, stall_mem=0, memwb_dmemload=dmemload, capture dmemload into an internal register, next state IDLE.
REQ-023 MemRead_in and MemWrite_in both 1: the write wins; dmemREN=0; memwb_dmemload holds its last captured value.
REQ-024 IDLE, exmem_valid=1, no mem op, Halt_in=0: memwb_writeEN=1, stall_mem=0, no cache request.
REQ-025 IDLE, exmem_valid=0: memwb_flush=1, memwb_writeEN=1, no cache request.
REQ-026 IDLE, exmem_valid=1, Halt_in=1:
  - Halt takes precedence over any mem op; no cache request is issued.
  - memwb_writeEN=1 for exactly one cycle; next state HALTED.
REQ-027 HALTED:
  - halt_o=1; stall_mem=1; memwb_writeEN=0; memwb_flush=0; no requests.
  - Leaves HALTED only on reset.
REQ-028 When no load completes, memwb_dmemload = captured register.
REQ-029 dhit while no request is outstanding is ignored.
REQ-030 mem_stall_cnt:
  - Increments by 1 each cycle the state is WAIT, including the cycle dhit arrives.
  - Saturates at 0xFFFF with no wrap.
REQ-031 Outside the cases above, memwb_flush=0, dmemREN=0, dmemWEN=0.

Reset
REQ-032 RST=1 immediately forces the following, regardless of CLK:
  - state=IDLE; captured register=0; mem_stall_cnt=0; halt_o=0.
REQ-033 RST=1 during WAIT abandons the request: dmemREN/dmemWEN drop to 0 asynchronously, and no MEM/WB write occurs for it.
REQ-034 During RST, outputs are driven from IDLE rules with exmem_valid treated as 0: all outputs 0 except memwb_flush=1 and memwb_writeEN=1.

Verification
REQ-035 Load hit: valid, MemRead, addr=0x100, dhit=1, dmemload=0xDEADBEEF -> dmemREN=1, memwb_writeEN=1, memwb_dmemload=0xDEADBEEF, stall_mem=0, same cycle.
REQ-036 Store miss 3 cycles: MemWrite, addr=0x200, data=0x12345678, dhit on 4th cycle -> stall_mem=1 for 3 cycles, dmemWEN stable throughout, single memwb_writeEN pulse, mem_stall_cnt=3.
REQ-037 Halt: valid, Halt_in=1, MemRead=1 -> one memwb_writeEN pulse, no dmemREN; then halt_o=1, stall_mem=1 held for 10+ cycles.
REQ-038 Bubble: exmem_valid=0 -> memwb_flush=1, memwb_writeEN=1, dmemREN=dmemWEN=0.
REQ-039 Reset mid-WAIT: assert RST between clock edges during a read miss -> dmemREN=0 immediately; after release, state IDLE and mem_stall_cnt=0.
REQ-040 Saturation: hold WAIT for 70000 cycles -> mem_stall_cnt=0xFFFF and stays there.
